// File: rtl/tetris_pkg.sv
// tetris_pkg: shared command opcodes and scheduler state encodings.
package tetris_pkg;
  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] GRAV  = 3'd1;
  localparam logic [2:0] ROT   = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;
  localparam logic [2:0] DROP  = 3'd5;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/move_scheduler_if.sv
// move_scheduler_if: command issue handshake between the scheduler and the piece datapath.
interface move_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_done;
  modport master (output cmd_valid, cmd_op, input cmd_ready, cmd_done);
  modport slave (input cmd_valid, cmd_op, output cmd_ready, cmd_done);
endinterface

// File: rtl/move_scheduler_repeat_timer.sv
// repeat_timer: DAS/ARR auto-repeat pulse generator for one held direction.
module repeat_timer #(
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic held,
  input  logic clear,
  output logic pulse
);
  localparam logic [CNT_W-1:0] DAS    = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DAS_DELAY - ARR_PERIOD + 1);
  logic [CNT_W-1:0] cnt;
  logic run;
  always_comb begin
    run   = held & ~clear;
    pulse = run & (cnt == DAS);
  end
  // cnt equals the number of cycles held so far; after a pulse it is rewound so the next fires ARR_PERIOD later
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else       cnt <= !run ? '0 : pulse ? RELOAD : cnt + CNT_W'(1);
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: serializes gravity and player requests into one-at-a-time datapath commands.
// Define MOVE_AUTO_REPEAT_EN to add DAS/ARR auto-repeat on left/right.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_active,
  input  logic             left,
  input  logic             right,
  input  logic             rotate,
  input  logic             drop,
  input  logic             tick,
  move_scheduler_if.master cmd,
  output logic             busy,
  output logic [CNT_W-1:0] lost_cnt
);
  state_t state, state_nxt;
  logic l_q, r_q, rot_q, drop_q;
  logic p_grav, p_rot, p_left, p_right, p_drop;
  logic rep_l, rep_r, le, re, rot_e, drop_e, grant;
  logic g_grav, g_rot, g_left, g_right, g_drop;
  logic k_left, k_right, n_left, n_right, lost_lr;
  logic [2:0] sel_op;
  logic [2:0] lost_inc;
  logic [CNT_W:0] lost_sum;
`ifdef MOVE_AUTO_REPEAT_EN
  repeat_timer #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_rep_l (
    .clk(clk), .reset(reset), .held(left & ~right), .clear(~game_active), .pulse(rep_l)
  );
  repeat_timer #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .CNT_W(CNT_W)) u_rep_r (
    .clk(clk), .reset(reset), .held(right & ~left), .clear(~game_active), .pulse(rep_r)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (DAS_DELAY == ARR_PERIOD);
  assign rep_l = 1'b0;
  assign rep_r = 1'b0;
`endif
  always_comb begin
    le       = (left & ~l_q) | rep_l;
    re       = (right & ~r_q) | rep_r;
    rot_e    = rotate & ~rot_q;
    drop_e   = drop & ~drop_q;
    grant    = (state == IDLE) & game_active & (p_grav | p_rot | p_left | p_right | p_drop);
    sel_op   = p_grav ? GRAV : p_rot ? ROT : p_left ? LEFT : p_right ? RIGHT : DROP;
    g_grav   = grant & (sel_op == GRAV);
    g_rot    = grant & (sel_op == ROT);
    g_left   = grant & (sel_op == LEFT);
    g_right  = grant & (sel_op == RIGHT);
    g_drop   = grant & (sel_op == DROP);
    k_left   = p_left & ~g_left;
    k_right  = p_right & ~g_right;
    n_left   = (le & re) ? k_left : le ? 1'b1 : re ? 1'b0 : k_left;
    n_right  = (le & re) ? k_right : re ? 1'b1 : le ? 1'b0 : k_right;
    // at most one of k_left/k_right survives, so a lone edge costs one merge or one cancel
    lost_lr  = (le & re) | ((le | re) & (k_left | k_right));
    lost_inc = 3'(lost_lr) + 3'(tick & p_grav & ~g_grav) + 3'(rot_e & p_rot & ~g_rot)
             + 3'(drop_e & p_drop & ~g_drop);
    lost_sum = {1'b0, lost_cnt} + (CNT_W+1)'(lost_inc);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) {l_q, r_q, rot_q, drop_q} <= '0;
    else       {l_q, r_q, rot_q, drop_q} <= {left, right, rotate, drop};
  always_ff @(posedge clk or posedge reset)
    if (reset || !game_active) {p_grav, p_rot, p_left, p_right, p_drop} <= '0;
    else begin
      p_grav  <= (p_grav & ~g_grav) | tick;
      p_rot   <= (p_rot & ~g_rot) | rot_e;
      p_left  <= n_left;
      p_right <= n_right;
      p_drop  <= (p_drop & ~g_drop) | drop_e;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset)            lost_cnt <= '0;
    else if (game_active) lost_cnt <= lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];
  always_ff @(posedge clk or posedge reset)
    if (reset)                                cmd.cmd_op <= NOP;
    else if (!game_active)                    cmd.cmd_op <= NOP;
    else if (grant)                           cmd.cmd_op <= sel_op;
    else if (state == WAIT && cmd.cmd_done)   cmd.cmd_op <= NOP;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt = !game_active    ? IDLE :
                state == IDLE   ? (grant ? ISSUE : IDLE) :
                state == ISSUE  ? (cmd.cmd_ready ? WAIT : ISSUE) :
                                  (cmd.cmd_done ? IDLE : WAIT);
  end
  always_comb begin
    cmd.cmd_valid = (state == ISSUE);
    busy          = (state != IDLE);
  end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: directed self-checking bench for move_scheduler with a simple datapath model.
module tb_move_scheduler;
  import tetris_pkg::*;
  logic clk = 0, reset = 1, game_active = 0;
  logic left = 0, right = 0, rotate = 0, drop = 0, tick = 0;
  logic dp_auto = 0, ready_man = 0, done_man = 0, dp_done = 0;
  int done_dly = 3, dp_cnt = 0;
  logic busy;
  logic [7:0] lost_cnt;
  logic [2:0] ops[$];
  int n_tests = 0, n_fail = 0;
  move_scheduler_if bus();
  assign bus.cmd_ready = dp_auto | ready_man;
  assign bus.cmd_done  = dp_done | done_man;
  move_scheduler #(.DAS_DELAY(16), .ARR_PERIOD(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .game_active(game_active), .left(left), .right(right),
    .rotate(rotate), .drop(drop), .tick(tick), .cmd(bus), .busy(busy), .lost_cnt(lost_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1; game_active = 1;
    {left, right, rotate, drop, tick} = '0;
    ready_man = 0; done_man = 0; dp_auto = 1; done_dly = 3;
    run(2);
    reset = 0;
    ops.delete();
  endtask
  function automatic int count_op(logic [2:0] op);
    int c = 0;
    foreach (ops[i]) if (ops[i] == op) c++;
    return c;
  endfunction
  // datapath model: records accepted ops at the edge, pulses done done_dly cycles later when automatic
  initial forever begin
    @(posedge clk);
    if (!reset && bus.cmd_valid && bus.cmd_ready) begin
      ops.push_back(bus.cmd_op);
      if (dp_auto) dp_cnt = done_dly;
    end
    @(negedge clk);
    dp_done = (dp_cnt == 1);
    if (dp_cnt > 0) dp_cnt--;
    if (reset) begin dp_cnt = 0; dp_done = 0; end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    run(2);
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_op", bus.cmd_op, NOP);
    check("rst_busy", busy, 0);
    check("rst_lost", lost_cnt, 0);
    // single left press, done 3 cycles after acceptance
    do_reset();
    left = 1;
    run(1); check("l_valid_n1", bus.cmd_valid, 0); left = 0;
    run(1); check("l_valid_n2", bus.cmd_valid, 1); check("l_op", bus.cmd_op, LEFT); check("l_busy_issue", busy, 1);
    run(1); check("l_valid_wait", bus.cmd_valid, 0); check("l_busy_wait", busy, 1);
    run(2); check("l_busy_pre_done", busy, 1);
    run(1); check("l_busy_after", busy, 0); check("l_op_nop", bus.cmd_op, NOP);
    check("l_count", ops.size(), 1);
    // tick and rotate together: GRAV first, then ROT
    do_reset();
    tick = 1; rotate = 1;
    run(1); tick = 0; rotate = 0;
    run(20);
    check("tr_count", ops.size(), 2);
    check("tr_first", ops[0], GRAV);
    check("tr_second", ops[1], ROT);
    check("tr_lost", lost_cnt, 0);
    // stalled handshake with two extra ticks merging into one pending GRAV
    do_reset();
    dp_auto = 0;
    tick = 1;
    run(1); tick = 0;
    run(1); check("st_valid0", bus.cmd_valid, 1); check("st_op0", bus.cmd_op, GRAV);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5) tick = 1;
      run(1);
      tick = 0;
      check("st_hold", {bus.cmd_valid, bus.cmd_op}, {1'b1, GRAV});
    end
    check("st_lost", lost_cnt, 1);
    ready_man = 1;
    run(1); ready_man = 0; done_man = 1;
    check("st_wait_busy", busy, 1);
    run(1); done_man = 0; dp_auto = 1;
    check("st_idle_valid", bus.cmd_valid, 0);
    run(1); check("st_reissue", {bus.cmd_valid, bus.cmd_op}, {1'b1, GRAV});
    run(10);
    check("st_count", count_op(GRAV), 2);
    check("st_total", ops.size(), 2);
    check("st_lost_end", lost_cnt, 1);
    // left and right in the same cycle cancel each other
    do_reset();
    left = 1; right = 1;
    run(1); left = 0; right = 0;
    run(10);
    check("lr_none", ops.size(), 0);
    check("lr_lost", lost_cnt, 1);
    // right one cycle after left while busy replaces the pending LEFT
    do_reset();
    tick = 1;
    run(1); tick = 0;
    run(1); left = 1;
    run(1); left = 0; right = 1;
    run(1); right = 0;
    run(20);
    check("lr2_count", ops.size(), 2);
    check("lr2_first", ops[0], GRAV);
    check("lr2_second", ops[1], RIGHT);
    check("lr2_lost", lost_cnt, 1);
    // game_active drop in WAIT abandons the command and pending ROT
    do_reset();
    dp_auto = 0; ready_man = 1;
    tick = 1;
    run(1); tick = 0;
    run(1); check("ga_valid", bus.cmd_valid, 1);
    run(1); check("ga_wait_busy", busy, 1); rotate = 1;
    run(1); rotate = 0; game_active = 0;
    run(1); check("ga_busy_off", busy, 0); check("ga_valid_off", bus.cmd_valid, 0);
    check("ga_op_nop", bus.cmd_op, NOP);
    game_active = 1;
    run(10);
    check("ga_no_rot", ops.size(), 1);
    check("ga_idle", busy, 0);
    // lost_cnt saturates
    do_reset();
    dp_auto = 0;
    tick = 1;
    run(300);
    tick = 0;
    check("sat_lost", lost_cnt, 255);
    check("sat_valid", {bus.cmd_valid, bus.cmd_op}, {1'b1, GRAV});
    // left held 30 cycles with an instant datapath
    do_reset();
    done_dly = 1;
    left = 1;
    run(30);
    left = 0;
    run(20);
`ifdef MOVE_AUTO_REPEAT_EN
    check("rep_left_count", count_op(LEFT), 5);
`else
    check("rep_left_count", count_op(LEFT), 1);
`endif
    check("rep_lost", lost_cnt, 0);
    // asynchronous reset mid-handshake
    do_reset();
    dp_auto = 0;
    tick = 1;
    run(1); tick = 0;
    run(1); check("ar_valid_pre", bus.cmd_valid, 1);
    reset = 1;
    #1;
    check("ar_valid", bus.cmd_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_op", bus.cmd_op, NOP);
    run(2);
    reset = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Arbitrates player inputs (left, right, rotate, drop) and the gravity tick into a single serialized command stream for the piece datapath.
- Ensures only one datapath operation is in flight at a time: a valid/ready issue handshake followed by a done wait.
- Sits between the debounced input/keyboard logic and the datapath, alongside the game-state FSM, which gates it with game_active.

Parameters:
- DAS_DELAY, 16, cycles left/right must be held before auto-repeat starts.
- ARR_PERIOD, 4, cycles between auto-repeat pulses once repeating.
- CNT_W, 8, width of the repeat timers and of the lost-request counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- game_active  input  1  high while a piece is controllable; low flushes everything
- left  input  1  level, move-left button
- right  input  1  level, move-right button
- rotate  input  1  level, rotate button
- drop  input  1  level, soft-drop button
- tick  input  1  one-cycle gravity pulse
- cmd_valid  output  1  command offered to the datapath
- cmd_ready  input  1  datapath accepts the command
- cmd_op  output  3  opcode: NOP=0, GRAV=1, ROT=2, LEFT=3, RIGHT=4, DROP=5
- cmd_done  input  1  one-cycle pulse when the accepted command completes
- busy  output  1  high in ISSUE or WAIT
- lost_cnt  output  CNT_W  saturating count of requests merged or discarded

Behaviour:
- Reset values: cmd_valid=0, cmd_op=NOP, busy=0, lost_cnt=0, all pending bits=0, edge registers=0, timers=0, state=IDLE.
- Edge detect: each button is registered once. A rising edge sets that source's pending bit on the next clock. A tick pulse sets pend_grav.
- Merging: if a request arrives while its pending bit is already set, the bit stays set and lost_cnt increments by 1.
- Left/right conflict:
  - Rising edges of left and right in the same cycle set neither pending bit; lost_cnt increments by 1.
  - A new left edge clears pend_right, and vice versa; lost_cnt increments by 1 if a bit was cleared.
- Priority: GRAV > ROT > LEFT > RIGHT > DROP, fixed.
- FSM:
  - IDLE: if game_active and any pending bit is set, latch the highest-priority opcode into cmd_op, clear that pending bit, go to ISSUE. cmd_valid rises the next cycle. Latency from button edge to cmd_valid is 2 cycles.
  - ISSUE: cmd_valid=1; cmd_op is held stable. On cmd_ready=1, go to WAIT and drop cmd_valid the next cycle.
  - WAIT: on cmd_done=1, go to IDLE with cmd_op=NOP. A new grant may be made on the cycle after returning to IDLE, so back-to-back issue spacing is at least 1 IDLE cycle.
- Pending bits keep accumulating during ISSUE and WAIT.
- cmd_done outside WAIT is ignored.
- game_active low in any state:
  - Clears all pending bits and timers; state goes to IDLE; cmd_valid goes to 0 on the next clock.
  - An in-flight WAIT is abandoned. The datapath is reset by the game FSM in that case.
- lost_cnt saturates at all-ones and is cleared only by reset.
- Reset asserted mid-handshake forces reset values immediately (asynchronous).

Optional Feature:
- Macro: MOVE_AUTO_REPEAT_EN.
- When defined:
  - While left (or right) is held, a per-direction timer counts from the rising edge.
  - At DAS_DELAY cycles it generates a repeat request, then another every ARR_PERIOD cycles, each treated exactly like a rising edge.
  - Release or game_active low resets the timer.
  - If both directions are held, no repeats occur.
- When undefined: only rising edges generate left/right requests and the timers are not instantiated.

Decomposition:
- Shared package tetris_pkg holds:
  - the cmd_op localparams (NOP, GRAV, ROT, LEFT, RIGHT, DROP, 3 bits);
  - the state encodings IDLE/ISSUE/WAIT.
- One natural sub-module, repeat_timer: one instance per direction, used only under MOVE_AUTO_REPEAT_EN.
  - Inputs: held, clear.
  - Output: one-cycle repeat pulse.
  - Parameters: DAS_DELAY, ARR_PERIOD, CNT_W.

Test Plan:
- Reset, then a left press with cmd_ready tied to 1 and cmd_done 3 cycles after acceptance -> cmd_valid rises 2 cycles after the edge with cmd_op=3; busy=1 until cmd_done; then cmd_op=0.
- tick and rotate edge in the same cycle while IDLE -> GRAV (1) issued first, then ROT (2) after the first cmd_done; lost_cnt=0.
- Hold cmd_ready=0 for 10 cycles after issue -> cmd_valid and cmd_op stay stable throughout; two extra tick pulses meanwhile -> one pending GRAV and lost_cnt=1.
- Left and right rising in the same cycle -> no command issued, lost_cnt=1. Left then right 1 cycle apart while busy -> only RIGHT is issued afterwards, lost_cnt=1.
- game_active dropped during WAIT with pending ROT -> state IDLE, cmd_valid=0 the next cycle, no ROT is ever issued.
- With MOVE_AUTO_REPEAT_EN, DAS_DELAY=16, ARR_PERIOD=4: hold left 30 cycles with an instant datapath -> LEFT requests at cycles 0, 16, 20, 24, 28 (5 commands). Without the macro -> exactly 1.
